// File: rtl/piece_move_if.sv
// Piece controller bus: frame/button inputs and the registered piece pose outputs.
interface piece_move_if;
  logic        vblnk;
  logic        btn_l;
  logic        btn_r;
  logic        btn_d;
  logic        btn_u;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [2:0]  block;
  logic [2:0]  rot;
  logic        lock;

  // Master supplies timing and buttons, slave (the controller) owns the pose.
  modport master (
    output vblnk, btn_l, btn_r, btn_d, btn_u,
    input  xpos, ypos, block, rot, lock
  );

  modport slave (
    input  vblnk, btn_l, btn_r, btn_d, btn_u,
    output xpos, ypos, block, rot, lock
  );
endinterface

// File: rtl/piece_move_ctl.sv
// Falling-piece controller: once per frame applies one queued move/rotate, then
// gravity; a piece that cannot fall further pulses lock and a new piece spawns.
// All pose updates land during vertical blanking so the drawn frame never tears.
module piece_move_ctl #(
  parameter int unsigned X_MIN       = 256,
  parameter int unsigned X_MAX       = 736,
  parameter int unsigned Y_MAX       = 704,
  parameter int unsigned STEP        = 32,
  parameter int unsigned FALL_FRAMES = 30,
  parameter int unsigned SPAWN_X     = 480,
  parameter int unsigned SPAWN_Y     = 0
) (
  input  logic         pclk,
  input  logic         rst,
  piece_move_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StMove, StFall, StLock, StSpawn} state_e;

  localparam int unsigned CntW = (FALL_FRAMES > 1) ? $clog2(FALL_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FALL_FRAMES - 1);
  localparam logic [12:0] Step13 = 13'(STEP);
  localparam logic [12:0] XMin13 = 13'(X_MIN);
  localparam logic [12:0] XMax13 = 13'(X_MAX);
  localparam logic [12:0] YMax13 = 13'(Y_MAX);

  state_e          state_q;
  logic [11:0]     xpos_q, ypos_q;
  logic [2:0]      block_q, rot_q;
  logic            lock_q;
  logic [CntW-1:0] fall_cnt_q;
  logic            vblnk_q;
  logic            btn_l_q, btn_r_q, btn_d_q, btn_u_q;
  logic            pend_l, pend_r, pend_d, pend_u;
  logic [7:0]      lfsr_q;

  logic        tick;
  logic        edge_l, edge_r, edge_d, edge_u;
  logic        clr_move, clr_d, clr_all;
  logic        grav;
  logic [12:0] x_ext, y_ext;
  logic        left_ok, right_ok, down_ok;
  logic [2:0]  spawn_block;

  assign tick   = bus.vblnk & ~vblnk_q;
  assign edge_l = bus.btn_l & ~btn_l_q;
  assign edge_r = bus.btn_r & ~btn_r_q;
  assign edge_d = bus.btn_d & ~btn_d_q;
  assign edge_u = bus.btn_u & ~btn_u_q;

  // Bounds checks are widened to 13 bits so xpos+STEP can never wrap.
  assign x_ext    = {1'b0, xpos_q};
  assign y_ext    = {1'b0, ypos_q};
  assign left_ok  = x_ext >= (XMin13 + Step13);
  assign right_ok = (x_ext + Step13) <= XMax13;
  assign down_ok  = (y_ext + Step13) <= YMax13;
  assign grav     = (fall_cnt_q == CntLast) | pend_d;

  assign spawn_block = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];

  // Decode which pending flags the current state consumes.
  always_comb begin
    clr_move = 1'b0;
    clr_d    = 1'b0;
    clr_all  = 1'b0;
    unique case (state_q)
      StMove:  clr_move = 1'b1;
      StFall:  clr_d    = grav;
      StSpawn: clr_all  = 1'b1;
      default: ;
    endcase
  end

  // Input history and free-running LFSR (taps 8,6,5,4).
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      btn_l_q <= 1'b0;
      btn_r_q <= 1'b0;
      btn_d_q <= 1'b0;
      btn_u_q <= 1'b0;
      lfsr_q  <= 8'hA5;
    end else begin
      vblnk_q <= bus.vblnk;
      btn_l_q <= bus.btn_l;
      btn_r_q <= bus.btn_r;
      btn_d_q <= bus.btn_d;
      btn_u_q <= bus.btn_u;
      lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Sticky per-button requests; a new edge beats a same-cycle clear.
  always_ff @(posedge pclk) begin
    if (rst) begin
      pend_l <= 1'b0;
      pend_r <= 1'b0;
      pend_d <= 1'b0;
      pend_u <= 1'b0;
    end else begin
      pend_l <= edge_l | (pend_l & ~(clr_move | clr_all));
      pend_r <= edge_r | (pend_r & ~(clr_move | clr_all));
      pend_u <= edge_u | (pend_u & ~(clr_move | clr_all));
      pend_d <= edge_d | (pend_d & ~(clr_d | clr_all));
    end
  end

  // Frame sequencer with registered pose outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= StIdle;
      xpos_q     <= 12'(SPAWN_X);
      ypos_q     <= 12'(SPAWN_Y);
      block_q    <= 3'd0;
      rot_q      <= 3'd0;
      lock_q     <= 1'b0;
      fall_cnt_q <= '0;
    end else begin
      lock_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tick) state_q <= StMove;
        end
        StMove: begin
          if (pend_u) begin
            rot_q <= {1'b0, rot_q[1:0] + 2'd1};
          end else if (pend_l) begin
            if (left_ok) xpos_q <= xpos_q - 12'(STEP);
          end else if (pend_r) begin
            if (right_ok) xpos_q <= xpos_q + 12'(STEP);
          end
          state_q <= StFall;
        end
        StFall: begin
          if (grav) begin
            fall_cnt_q <= '0;
            if (down_ok) begin
              ypos_q  <= ypos_q + 12'(STEP);
              state_q <= StIdle;
            end else begin
              lock_q  <= 1'b1;
              state_q <= StLock;
            end
          end else begin
            fall_cnt_q <= fall_cnt_q + CntW'(1);
            state_q    <= StIdle;
          end
        end
        StLock: begin
          state_q <= StSpawn;
        end
        StSpawn: begin
          xpos_q     <= 12'(SPAWN_X);
          ypos_q     <= 12'(SPAWN_Y);
          rot_q      <= 3'd0;
          block_q    <= spawn_block;
          fall_cnt_q <= '0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.xpos  = xpos_q;
  assign bus.ypos  = ypos_q;
  assign bus.block = block_q;
  assign bus.rot   = rot_q;
  assign bus.lock  = lock_q;

endmodule

// File: tb/tb_piece_move_ctl.sv
// Directed bench for piece_move_ctl with a behavioural pose model feeding a
// scoreboard queue that is drained as each MOVE/FALL result appears.
module tb_piece_move_ctl;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  piece_move_if bus ();

  piece_move_ctl dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  r;
    logic        lk;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int lock_cnt = 0;

  // Behavioural model state.
  int  mx, my, mr, mcnt;
  bit  p_l, p_r, p_d, p_u;

  always @(posedge pclk) if (bus.lock === 1'b1) lock_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic lk);
    exp_t e;
    e.x = 12'(mx);
    e.y = 12'(my);
    e.r = 3'(mr);
    e.lk = lk;
    q.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_x"},    32'(bus.xpos), 32'(e.x));
      chk({tag, "_y"},    32'(bus.ypos), 32'(e.y));
      chk({tag, "_rot"},  32'(bus.rot),  32'(e.r));
      chk({tag, "_lock"}, 32'(bus.lock), 32'(e.lk));
    end
  endtask

  task automatic model_reset();
    mx = 480; my = 0; mr = 0; mcnt = 0;
    p_l = 0; p_r = 0; p_d = 0; p_u = 0;
  endtask

  task automatic do_reset();
    @(posedge pclk); #1;
    rst = 1'b1;
    bus.vblnk = 1'b0;
    bus.btn_l = 1'b0; bus.btn_r = 1'b0; bus.btn_d = 1'b0; bus.btn_u = 1'b0;
    @(posedge pclk);
    @(posedge pclk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_x",     32'(bus.xpos),  32'd480);
    chk("rst_y",     32'(bus.ypos),  32'd0);
    chk("rst_block", 32'(bus.block), 32'd0);
    chk("rst_rot",   32'(bus.rot),   32'd0);
    chk("rst_lock",  32'(bus.lock),  32'd0);
  endtask

  // 0=left 1=right 2=down 3=rotate; bits select which buttons pulse together.
  task automatic press(input logic [3:0] b);
    @(posedge pclk); #1;
    bus.btn_l = b[0]; bus.btn_r = b[1]; bus.btn_d = b[2]; bus.btn_u = b[3];
    if (b[0]) p_l = 1;
    if (b[1]) p_r = 1;
    if (b[2]) p_d = 1;
    if (b[3]) p_u = 1;
    @(posedge pclk);
    @(posedge pclk); #1;
    bus.btn_l = 1'b0; bus.btn_r = 1'b0; bus.btn_d = 1'b0; bus.btn_u = 1'b0;
    @(posedge pclk);
  endtask

  task automatic model_move();
    if (p_u) mr = (mr + 1) % 4;
    else if (p_l) begin if (mx >= 256 + 32) mx -= 32; end
    else if (p_r) begin if (mx + 32 <= 736) mx += 32; end
    p_u = 0; p_l = 0; p_r = 0;
  endtask

  // Returns 1 when the gravity step cannot move the piece (it lands).
  function automatic bit model_fall();
    bit land = 0;
    if (mcnt == 29 || p_d) begin
      mcnt = 0; p_d = 0;
      if (my + 32 <= 704) my += 32;
      else land = 1;
    end else begin
      mcnt++;
    end
    return land;
  endfunction

  task automatic frame();
    bit land;
    int lk0;
    model_move();
    push_exp(1'b0);
    land = model_fall();
    push_exp(land);
    lk0 = lock_cnt;
    @(posedge pclk); #1 bus.vblnk = 1'b1;
    @(posedge pclk);
    @(posedge pclk); #1 check_pop("move");
    @(posedge pclk); #1 check_pop("fall");
    if (land) begin
      @(posedge pclk); #1 chk("lock_off", 32'(bus.lock), 32'd0);
      @(posedge pclk); #1;
      model_reset();
      chk("spawn_x",   32'(bus.xpos), 32'd480);
      chk("spawn_y",   32'(bus.ypos), 32'd0);
      chk("spawn_rot", 32'(bus.rot),  32'd0);
      chk("spawn_block_range", 32'(bus.block < 3'd7), 32'd1);
      chk("lock_pulses", 32'(lock_cnt - lk0), 32'd1);
    end else begin
      repeat (2) @(posedge pclk);
    end
    @(posedge pclk); #1 bus.vblnk = 1'b0;
    repeat (4) @(posedge pclk);
  endtask

  initial begin
    int lk0;
    bus.vblnk = 1'b0;
    bus.btn_l = 1'b0; bus.btn_r = 1'b0; bus.btn_d = 1'b0; bus.btn_u = 1'b0;
    model_reset();

    // Right move from spawn.
    do_reset();
    press(4'b0010);
    frame();

    // Walk to the left wall, then left+rotate together at the wall.
    repeat (8) begin press(4'b0001); frame(); end
    press(4'b1001);
    frame();
    frame();
    // Walk to the right wall and push past it.
    repeat (15) begin press(4'b0010); frame(); end
    press(4'b0010);
    frame();

    // Four rotations wrap back to 0.
    repeat (4) begin press(4'b1000); frame(); end

    // Gravity every 30th frame; a down press steps at once and restarts the count.
    do_reset();
    repeat (30) frame();
    press(4'b0100);
    frame();
    repeat (30) frame();

    // vblnk held high: only one MOVE for the whole blanking period.
    do_reset();
    press(4'b0010);
    model_move();
    void'(model_fall());
    push_exp(1'b0);
    @(posedge pclk); #1 bus.vblnk = 1'b1;
    repeat (4) @(posedge pclk);
    press(4'b0010);
    repeat (990) @(posedge pclk);
    #1 check_pop("hold");
    bus.vblnk = 1'b0;
    repeat (4) @(posedge pclk);
    frame();

    // Reset asserted during the FALL cycle of a landing frame.
    do_reset();
    repeat (22) begin press(4'b0100); frame(); end
    press(4'b0100);
    lk0 = lock_cnt;
    @(posedge pclk); #1 bus.vblnk = 1'b1;
    @(posedge pclk);
    @(posedge pclk); #1 rst = 1'b1;
    @(posedge pclk); #1;
    chk("rstfall_x",     32'(bus.xpos),  32'd480);
    chk("rstfall_y",     32'(bus.ypos),  32'd0);
    chk("rstfall_block", 32'(bus.block), 32'd0);
    chk("rstfall_rot",   32'(bus.rot),   32'd0);
    chk("rstfall_lock",  32'(bus.lock),  32'd0);
    rst = 1'b0;
    bus.vblnk = 1'b0;
    model_reset();
    repeat (10) @(posedge pclk);
    #1 chk("rstfall_no_lock", 32'(lock_cnt - lk0), 32'd0);
    chk("rstfall_y_hold", 32'(bus.ypos), 32'd0);

    // Descend to the floor and land.
    do_reset();
    repeat (22) begin press(4'b0100); frame(); end
    press(4'b0100);
    frame();
    frame();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piece_move_ctl.md
PIECE_MOVE_CTL -- requirements
Module: piece_move_ctl

Interface
REQ-001 Parameter X_MIN, default 256: leftmost legal xpos.
REQ-002 Parameter X_MAX, default 736: rightmost legal xpos.
REQ-003 Parameter Y_MAX, default 704: lowest legal ypos.
REQ-004 Parameter STEP, default 32: cell size in pixels per move.
REQ-005 Parameter FALL_FRAMES, default 30: frames per gravity step, at least 1.
REQ-006 Parameter SPAWN_X, default 480: xpos after reset and after spawn.
REQ-007 Parameter SPAWN_Y, default 0: ypos after reset and after spawn.
REQ-008 Port pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 Port vblnk, input, 1 bit: vertical blanking from vga_timing; its rising edge is the frame tick.
REQ-011 Ports btn_l, btn_r, btn_d and btn_u, inputs, 1 bit each: debounced button levels (move left, right, down, rotate).
REQ-012 Port xpos, output, 12 bits: piece x origin, registered, drives draw_rect.
REQ-013 Port ypos, output, 12 bits: piece y origin, registered.
REQ-014 Port block, output, 3 bits: piece type, 0..6, registered.
REQ-015 Port rot, output, 3 bits: rotation, 0..3 with bit 2 always 0, registered.
REQ-016 Port lock, output, 1 bit: single-cycle pulse when a piece lands.

Function
REQ-017 The block SHALL sample vblnk into vblnk_q every cycle; tick = vblnk & ~vblnk_q, at most one tick per rising edge.
REQ-018 The block SHALL detect rising edges of each button against a registered copy and set a sticky pending flag per button (pend_l, pend_r, pend_d, pend_u).
REQ-019 The FSM SHALL have states IDLE, MOVE, FALL, LOCK and SPAWN; the reset state is IDLE.
REQ-020 IDLE SHALL go to MOVE on tick; a tick in any other state SHALL be ignored.
REQ-021 MOVE lasts one cycle, applies at most one action and then goes to FALL.
REQ-022 MOVE action priority SHALL be pend_u, then pend_l, then pend_r.
REQ-023 The pend_u action SHALL set rot to (rot+1) mod 4.
REQ-024 The pend_l action SHALL set xpos to xpos-STEP only if xpos >= X_MIN+STEP; otherwise xpos is unchanged.
REQ-025 The pend_r action SHALL set xpos to xpos+STEP only if xpos+STEP <= X_MAX; otherwise xpos is unchanged.
REQ-026 All comparisons SHALL use 13-bit unsigned arithmetic with no wrap.
REQ-027 MOVE SHALL clear pend_u, pend_l and pend_r, including unused lower-priority flags.
REQ-028 A button edge in the same cycle as a clear SHALL leave its flag set (set wins).
REQ-029 In FALL, the fall counter increments; a gravity step occurs when the counter reaches FALL_FRAMES-1 or pend_d is set.
REQ-030 A gravity step SHALL clear the fall counter and pend_d.
REQ-031 On a gravity step, if ypos+STEP <= Y_MAX, ypos SHALL become ypos+STEP and the FSM returns to IDLE; otherwise the FSM goes to LOCK with ypos unchanged.
REQ-032 With no gravity step, FALL SHALL return to IDLE.
REQ-033 LOCK SHALL assert lock for exactly one cycle and then go to SPAWN.
REQ-034 SPAWN SHALL set xpos=SPAWN_X, ypos=SPAWN_Y and rot=0, clear all pending flags and the fall counter, and return to IDLE.
REQ-035 In SPAWN, block SHALL be lfsr[2:0], replaced by 0 when that value is 7.
REQ-036 An 8-bit LFSR SHALL advance every cycle: Fibonacci, taps 8,6,5,4, shifting left, feedback into bit 0.
REQ-037 Latency: with tick in cycle t, the MOVE result is visible at cycle t+2 and the FALL result at t+3; spawn values are visible at t+5.
REQ-038 xpos, ypos, block and rot SHALL change only on the edges that end MOVE, FALL or SPAWN, which all occur during vblnk (tear-free).

Reset
REQ-039 With rst high at a clock edge, the block SHALL set xpos=SPAWN_X, ypos=SPAWN_Y, block=0, rot=0, lock=0, state IDLE, fall counter 0, all pending flags 0, button and vblnk history 0, and lfsr=8'hA5.
REQ-040 rst SHALL take priority over all other inputs in any state, including mid-sequence, and no lock pulse SHALL follow a reset.

Verification
REQ-041 Reset, then one btn_r pulse, then a vblnk rise -> xpos 480 to 512 at t+2, ypos still 0.
REQ-042 With xpos=256, btn_l and btn_u pressed in the same frame -> rot 0 to 1, xpos stays 256, pend_l cleared; with xpos=736, btn_r -> xpos stays 736.
REQ-043 30 vblnk rises with no buttons -> ypos 0 to 32 on the 30th frame only; a btn_d pulse -> ypos +32 on the next frame and the fall counter resets.
REQ-044 With ypos=704, a gravity step -> lock high for exactly 1 cycle; then at t+5 xpos=480, ypos=0, rot=0, block in 0..6.
REQ-045 rst asserted in the FALL cycle -> all outputs at reset values the next cycle and no lock pulse; vblnk held high for 1000 cycles -> exactly one MOVE.
REQ-046 Four rotate frames -> rot sequence 1, 2, 3, 0, with rot[2]=0 throughout.
